// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
// Bit-serial add/subtract sequencer. Operands are latched on start and fed
// LSB-first through one full adder/subtractor cell, one bit per clock. The
// carry/borrow is kept in a register between bits. The result, carry/borrow-out
// and signed overflow are published once, on the edge that finishes the last bit.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  // Counter only has to reach WIDTH-1; WIDTH >= 2 keeps this at least 1 bit.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working registers. The operand registers shift right, so the bit under
  // work is always at position 0. The accumulator fills from the MSB end, so
  // after WIDTH shifts bit 0 of the result has reached position 0.
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic             sub_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;

  // One-bit arithmetic cell and completion terms.
  logic             a_bit;
  logic             b_bit;
  logic             s_bit;
  logic             c_nxt;
  logic             last_bit;
  logic             ovf_nxt;
  logic [WIDTH-1:0] acc_nxt;

  // One-bit full adder/subtractor over the current operand bits and the stored carry/borrow.
  always_comb begin
    a_bit = opa_q[0];
    b_bit = opb_q[0];
    // The sum bit and the difference bit use the same equation.
    s_bit = a_bit ^ b_bit ^ c_q;
    if (sub_q) begin
      c_nxt = (~a_bit & b_bit) | (c_q & ~(a_bit ^ b_bit));
    end else begin
      c_nxt = (a_bit & b_bit) | (c_q & (a_bit ^ b_bit));
    end
    acc_nxt  = {s_bit, acc_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
    // On the last bit, a_bit and b_bit are the operand MSBs and s_bit is the result MSB.
    if (sub_q) begin
      ovf_nxt = (a_bit != b_bit) && (s_bit != a_bit);
    end else begin
      ovf_nxt = (a_bit == b_bit) && (s_bit != a_bit);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // sample their inputs from before the edge, so the order of statements
    // within and across always_ff blocks does not matter.
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the status outputs decoded from the state.
  always_comb begin
    // NOTE: every signal gets a default before the case. A path that leaves
    // a combinational output unassigned would infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on acceptance, run one bit per SHIFT cycle, and publish results on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is a plain flop and is cleared here.
    // An aborted operation must leave no trace in the outputs or the working
    // state. This is not a memory array, so resetting it costs nothing unusual.
    if (!rst_n) begin
      opa_q  <= '0;
      opb_q  <= '0;
      acc_q  <= '0;
      sub_q  <= 1'b0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            opa_q <= a;
            opb_q <= b;
            sub_q <= sub;
            c_q   <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
          end
        end
        ST_SHIFT: begin
          opa_q <= opa_q >> 1;
          opb_q <= opb_q >> 1;
          c_q   <= c_nxt;
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            result <= acc_nxt;
            cout   <= c_nxt;
            ovf    <= ovf_nxt;
          end
        end
        default: begin
          // DONE: outputs and working registers hold their values.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl
// Self-checking bench for serial_addsub_ctrl (WIDTH=8). Expected values come
// from an arithmetic model: integer add/subtract, with signed range checks.
`timescale 1ns/1ps
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int passes = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so that a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic ms, output logic [W-1:0] r,
                                output logic c, output logic v);
    int ua, ub, full, sa, sb, sres;
    ua = int'(ma);
    ub = int'(mb);
    full = ms ? (ua - ub) : (ua + ub);
    r = W'(full);
    c = ms ? (ua < ub) : (full >= (1 << W));
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sres = ms ? (sa - sb) : (sa + sb);
    v = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
  endfunction

  // Start one operation and wait for done. On return the bench sits at the
  // negedge inside the done cycle. lat is the number of edges from the start
  // edge to done, or -1 on timeout. viol counts the cycles where busy was low
  // or an output moved before done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, output int lat, output int viol);
    logic [W-1:0] r0;
    logic c0, v0;
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    r0 = result; c0 = cout; v0 = ovf;
    viol = 0;
    lat = -1;
    @(negedge clk);
    start = 1'b0;
    if (!busy) viol++;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        if (!busy) viol++;
        lat = k;
        break;
      end
      if (!busy || result !== r0 || cout !== c0 || ovf !== v0) viol++;
    end
  endtask

  // Run one operation and compare it with the model.
  task automatic test_op(input string nm, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic ts);
    int lat, viol;
    logic [W-1:0] er;
    logic ec, ev;
    model(ta, tb, ts, er, ec, ev);
    run_op(ta, tb, ts, lat, viol);
    checks++; if (lat !== W) $display("FAIL %s latency: got %0d want %0d", nm, lat, W); else passes++;
    checks++; if (viol !== 0) $display("FAIL %s busy/hold: got %0d bad cycles want 0", nm, viol); else passes++;
    checks++; if (result !== er) $display("FAIL %s result (a=%h b=%h sub=%0d): got %h want %h", nm, ta, tb, ts, result, er); else passes++;
    checks++; if (cout !== ec) $display("FAIL %s cout: got %0d want %0d", nm, cout, ec); else passes++;
    checks++; if (ovf !== ev) $display("FAIL %s ovf: got %0d want %0d", nm, ovf, ev); else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, cout, ovf} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy, done, cout, ovf}); else passes++;
    checks++; if (result !== '0) $display("FAIL reset_result: got %h want 00", result); else passes++;
    start = 1'b0;
    rst_n = 1'b1;
    // Load non-zero outputs, then check that reset clears them without a clock edge.
    test_op("reset_pre", 8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    #2;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); start = 1'($urandom);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, cout, ovf} !== 4'b0) $display("FAIL reset_async_flags: got %b want 0000", {busy, done, cout, ovf}); else passes++;
    checks++; if (result !== '0) $display("FAIL reset_async_result: got %h want 00", result); else passes++;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    test_op("add_5A_3C", 8'h5A, 8'h3C, 1'b0);
    test_op("add_FF_01", 8'hFF, 8'h01, 1'b0);
    test_op("add_7F_01", 8'h7F, 8'h01, 1'b0);
    test_op("add_80_80", 8'h80, 8'h80, 1'b0);
  endtask

  task automatic test_sub();
    test_op("sub_05_07", 8'h05, 8'h07, 1'b1);
    test_op("sub_80_01", 8'h80, 8'h01, 1'b1);
    test_op("sub_00_00", 8'h00, 8'h00, 1'b1);
    test_op("sub_7F_FF", 8'h7F, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      test_op("random", W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_busy_protect();
    int ndone;
    logic seen;
    seen = 1'b0;
    ndone = 0;
    @(negedge clk);
    a = 8'h21; b = 8'h43; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        ndone++;
        // Request again with new operands while still in DONE.
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); start = 1'b1;
      end else begin
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); start = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (done) ndone++;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone !== 1) $display("FAIL busy_protect_done_count: got %0d want 1", ndone); else passes++;
    checks++; if ({result, cout, ovf} !== {8'h64, 1'b0, 1'b0}) $display("FAIL busy_protect_result: got %h/%0d/%0d want 64/0/0", result, cout, ovf); else passes++;
  endtask

  task automatic test_back_to_back();
    int times[$];
    int viol;
    logic prev;
    logic [W-1:0] er;
    logic ec, ev;
    viol = 0;
    prev = 1'b0;
    model(8'hA7, 8'h3B, 1'b1, er, ec, ev);
    @(negedge clk);
    a = 8'hA7; b = 8'h3B; sub = 1'b1; start = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        times.push_back(cyc);
        if (prev || !busy) viol++;
        if ({result, cout, ovf} !== {er, ec, ev}) viol++;
      end
      prev = done;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (times.size() < 4) $display("FAIL b2b_done_count: got %0d want >=4", times.size()); else passes++;
    for (int i = 1; i < times.size(); i++) begin
      checks++; if (times[i] - times[i-1] !== W + 2) $display("FAIL b2b_period: got %0d want %0d", times[i] - times[i-1], W + 2); else passes++;
    end
    checks++; if (viol !== 0) $display("FAIL b2b_pulse_result: got %0d bad done cycles want 0", viol); else passes++;
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, cout, ovf} !== 4'b0) $display("FAIL reset_mid_flags: got %b want 0000", {busy, done, cout, ovf}); else passes++;
    checks++; if (result !== '0) $display("FAIL reset_mid_result: got %h want 00", result); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL reset_mid_no_done: got %0d active cycles want 0", bad); else passes++;
    test_op("after_reset_12_34", 8'h12, 8'h34, 1'b0);
  endtask

  task automatic test_hold();
    test_op("hold_01_02", 8'h01, 8'h02, 1'b0);
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    repeat (20) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      checks++; if (result !== 8'h03 || busy !== 1'b0) $display("FAIL hold: got result=%h busy=%0d want 03/0", result, busy); else passes++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_add();
    test_sub();
    test_random();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
